// File: rtl/id_stage.sv
// Instruction-decode stage of a five-stage MIPS-subset pipeline.
// It contains the IF/ID pipeline register, a 32x32 register file with an
// optional write-back bypass, the instruction decoder, branch/jump
// resolution toward fetch, and the registered ID/EX bundle.
module id_stage #(
    parameter int BYPASS_EN = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] instruction,
    input  logic [31:0] PCplus4,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        PCSrc,
    output logic [31:0] PCSrc_immediate,
    output logic        Jump,
    output logic [25:0] Jump_immediate,
    output logic        ex_valid,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic [31:0] ex_pcplus4
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_SLT = 6'h2A
    } funct_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    // IF/ID register
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;

    // Register file
    logic [31:0] regs [32];

    // Decode results
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_sext;
    logic        dec_legal;
    logic        dec_beq;
    logic        dec_jump;
    alu_op_t     dec_alu_op;
    logic        dec_alu_src;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic [4:0]  dec_rd;
    logic        flush;

    assign rs_addr  = id_instr[25:21];
    assign rt_addr  = id_instr[20:16];
    assign imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};

    // IF/ID: load when not stalled; a taken redirect invalidates the wrong-path word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc4   <= '0;
        end else if (!stall) begin
            id_valid <= if_valid && !flush;
            id_instr <= instruction;
            id_pc4   <= PCplus4;
        end
    end

    // Register-file write port; $0 is never written so it stays zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read port rs with optional same-cycle write-back forwarding.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if ((BYPASS_EN != 0) && wb_we && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end
    end

    // Read port rt with optional same-cycle write-back forwarding.
    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if ((BYPASS_EN != 0) && wb_we && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end
    end

    // Instruction decoder; anything not recognised leaves dec_legal low.
    always_comb begin
        dec_legal     = 1'b0;
        dec_beq       = 1'b0;
        dec_jump      = 1'b0;
        dec_alu_op    = ALU_ADD;
        dec_alu_src   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_rd        = rt_addr;
        case (id_instr[31:26])
            OP_RTYPE: begin
                dec_rd = id_instr[15:11];
                case (id_instr[5:0])
                    FN_ADD: begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
                    FN_SUB: begin dec_legal = 1'b1; dec_alu_op = ALU_SUB; end
                    FN_AND: begin dec_legal = 1'b1; dec_alu_op = ALU_AND; end
                    FN_OR:  begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  end
                    FN_SLT: begin dec_legal = 1'b1; dec_alu_op = ALU_SLT; end
                    default: dec_legal = 1'b0;
                endcase
                dec_reg_write = dec_legal;
            end
            OP_LW: begin
                dec_legal     = 1'b1;
                dec_alu_src   = 1'b1;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_SW: begin
                dec_legal     = 1'b1;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_ADDI: begin
                dec_legal     = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_BEQ:  dec_beq  = 1'b1;
            OP_J:    dec_jump = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Fetch redirects are suppressed while stalled or when ID holds no word.
    always_comb begin
        PCSrc           = id_valid && !stall && dec_beq && (rs_data == rt_data);
        Jump            = id_valid && !stall && dec_jump;
        PCSrc_immediate = id_valid ? imm_sext : '0;
        Jump_immediate  = id_valid ? id_instr[25:0] : '0;
        flush           = PCSrc || Jump;
    end

    // ID/EX: data fields follow decode every edge; control bits are zeroed for bubbles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid     <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_pcplus4   <= '0;
        end else begin
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_imm     <= imm_sext;
            ex_rd      <= dec_rd;
            ex_alu_op  <= dec_alu_op;
            ex_alu_src <= dec_alu_src;
            ex_pcplus4 <= id_pc4;
            if (stall || !id_valid || !dec_legal) begin
                ex_valid     <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_reg_write <= 1'b0;
            end else begin
                ex_valid     <= 1'b1;
                ex_mem_read  <= dec_mem_read;
                ex_mem_write <= dec_mem_write;
                ex_reg_write <= dec_reg_write;
            end
        end
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: BYPASS_EN, default 1, 1 = write-back data forwarded to same-cycle register reads; 0 = no forwarding.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 instruction  input  32  fetched word from the fetch stage.
REQ-005 PCplus4  input  32  fetch address + 4 for that word.
REQ-006 if_valid  input  1  instruction/PCplus4 valid this cycle.
REQ-007 stall  input  1  downstream hazard hold.
REQ-008 wb_we / wb_addr / wb_data  input  1/5/32  register-file write port.
REQ-009 PCSrc  output  1  taken-branch request to fetch (combinational).
REQ-010 PCSrc_immediate  output  32  sign-extended 16-bit offset, unshifted; fetch applies <<2 and add.
REQ-011 Jump  output  1  jump request to fetch (combinational).
REQ-012 Jump_immediate  output  26  instr[25:0] of the jump.
REQ-013 ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_pcplus4  output  1/32/32/32/5/3/1/1/1/1/32  registered ID/EX bundle.

Function
REQ-014 IF/ID register (id_instr, id_pc4, id_valid) SHALL load instruction, PCplus4, if_valid on rising CLK when stall=0; hold when stall=1.
REQ-015 Register file SHALL be 32x32, two combinational read ports (rs=id_instr[25:21], rt=id_instr[20:16]), one write port written on rising CLK when wb_we=1 and wb_addr!=0.
REQ-016 Register 0 SHALL always read 0; writes to it ignored.
REQ-017 With BYPASS_EN=1, a read whose address equals wb_addr (nonzero) while wb_we=1 SHALL return wb_data the same cycle.
REQ-018 Decode (id_valid=1): R-type op 0x00 funct 0x20/0x22/0x24/0x25/0x2A -> alu_op 000/001/010/011/100, rd=instr[15:11], reg_write=1, alu_src=0.
REQ-019 lw 0x23: alu_op 000, alu_src 1, mem_read 1, reg_write 1, rd=rt; sw 0x2B: alu_op 000, alu_src 1, mem_write 1; addi 0x08: alu_op 000, alu_src 1, reg_write 1, rd=rt.
REQ-020 beq 0x04: PCSrc=1 when rs data == rt data (after bypass), else 0; ID/EX entry is a bubble.
REQ-021 j 0x02: Jump=1, Jump_immediate=instr[25:0]; ID/EX entry is a bubble.
REQ-022 Any other opcode/funct (including 0x00000000) SHALL produce a bubble (ex_valid=0), no fetch redirect.
REQ-023 ex_imm and PCSrc_immediate SHALL equal sign-extension of instr[15:0] for all opcodes.
REQ-024 PCSrc and Jump SHALL be 0 when id_valid=0 or stall=1; stall overrides a taken branch/jump until stall deasserts.
REQ-025 Flush: a cycle with PCSrc=1 or Jump=1 SHALL load id_valid=0 at the next edge regardless of if_valid (wrong-path word discarded).
REQ-026 ID/EX register SHALL update every rising edge: when stall=1 or id_valid=0 or bubble, ex_valid=0 and ex_mem_read/ex_mem_write/ex_reg_write=0; otherwise decoded fields, ex_valid=1.
REQ-027 Decode-to-ex latency SHALL be exactly 1 cycle; fetch-to-ex latency 2 cycles absent stall.

Reset
REQ-028 RST=1 SHALL immediately clear id_valid, id_instr, id_pc4, all ex_* outputs to 0, independent of CLK.
REQ-029 Register-file contents SHALL reset to 0.
REQ-030 With id_valid=0 after reset, PCSrc=0, Jump=0, PCSrc_immediate=0, Jump_immediate=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight IF/ID and ID/EX contents; first valid ex_* appears 2 edges after first if_valid following RST deassert.

Verification
REQ-032 Reset: assert RST between edges -> all outputs 0 before next edge; release, feed no if_valid -> ex_valid stays 0.
REQ-033 Write-back/bypass: wb_we=1, wb_addr=8, wb_data=5 while ID holds addi $9,$8,3 (0x21090003) -> ex_rs_data=5, ex_imm=3, ex_rd=9, ex_reg_write=1; wb_addr=0 write -> $0 reads 0.
REQ-034 Branch: $1=$2=7, beq $1,$2,16 (0x10220010) -> PCSrc=1, PCSrc_immediate=16 same cycle; next-edge id_valid=0; ex_valid=0. With $2=8 -> PCSrc=0.
REQ-035 Jump: j 4 (0x08000004) -> Jump=1, Jump_immediate=4; following fetched word flushed.
REQ-036 Stall: lw $3,-4($1) (0x8C23FFFC) held with stall=1 for 2 cycles -> ex_valid=0 both cycles, IF/ID unchanged; release -> ex_mem_read=1, ex_imm=0xFFFFFFFC, ex_rd=3.
REQ-037 Stall concurrent with beq taken -> PCSrc=0 while stalled, PCSrc=1 in first unstalled cycle.
